// File: rtl/eeprom_word_ctrl.sv
// Word-wide sequencer for four byte-lane EEPROM chips sharing address and strobes.
// Turns single-word read/write requests into timed CE/OE/WE sequences.
module eeprom_word_ctrl #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned T_AS   = 1,
  parameter int unsigned T_ACC  = 4,
  parameter int unsigned T_WP   = 3,
  parameter int unsigned T_WC   = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic [ADDR_W-1:0] ee_a_o,
  output logic              ee_ce_n_o,
  output logic              ee_oe_n_o,
  output logic              ee_we_n_o,
  output logic              ee_io_oe_o,
  output logic [31:0]       ee_io_out_o,
  input  logic [31:0]       ee_io_in_i
);

  localparam int unsigned MaxRd = (T_AS > T_ACC) ? T_AS : T_ACC;
  localparam int unsigned MaxWr = (T_WP > T_WC) ? T_WP : T_WC;
  localparam int unsigned MaxT  = (MaxRd > MaxWr) ? MaxRd : MaxWr;
  localparam int unsigned CntW  = (MaxT > 1) ? $clog2(MaxT) : 1;

  // Counter holds remaining cycles minus one; a phase ends when it reads zero.
  localparam logic [CntW-1:0] LdAs  = CntW'(T_AS - 1);
  localparam logic [CntW-1:0] LdAcc = CntW'(T_ACC - 1);
  localparam logic [CntW-1:0] LdWp  = CntW'(T_WP - 1);
  localparam logic [CntW-1:0] LdWc  = CntW'(T_WC - 1);

  typedef enum logic [2:0] {
    StIdle, StSetup, StRdAcc, StWrPulse, StWrHold, StWrRec, StRsp
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              io_oe_q, io_oe_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              req_ready_q, req_ready_d;
  logic              accept, load_rd, load_wr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    load_rd = 1'b0;
    load_wr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i && req_ready_q) begin
          accept  = 1'b1;
          state_d = StSetup;
          cnt_d   = LdAs;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = we_q ? StWrPulse : StRdAcc;
          cnt_d   = we_q ? LdWp : LdAcc;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRdAcc: begin
        if (cnt_q == '0) begin
          state_d = StRsp;
          load_rd = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWrPulse: begin
        if (cnt_q == '0) begin
          state_d = StWrHold;
          load_wr = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWrHold: begin
        state_d = StWrRec;
        cnt_d   = LdWc;
      end
      StWrRec: begin
        if (cnt_q == '0) begin
          state_d = StRsp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRsp: begin
        if (rsp_valid_q && rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    we_d    = accept ? req_we_i    : we_q;
    addr_d  = accept ? req_addr_i  : addr_q;
    wdata_d = accept ? req_wdata_i : wdata_q;
    rdata_d = rdata_q;
    if (load_rd) begin
      rdata_d = ee_io_in_i;
    end else if (load_wr) begin
      rdata_d = wdata_q;
    end
    // Outputs are decoded from the next state so they are registered yet aligned with it.
    ce_n_d      = !(state_d inside {StSetup, StRdAcc, StWrPulse, StWrHold});
    oe_n_d      = (state_d != StRdAcc);
    we_n_d      = (state_d != StWrPulse);
    io_oe_d     = ((state_d == StSetup) && we_d) || (state_d == StWrPulse) ||
                  (state_d == StWrHold);
    rsp_valid_d = (state_d == StRsp);
    req_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      io_oe_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      io_oe_q     <= io_oe_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign ee_a_o      = addr_q;
  assign ee_ce_n_o   = ce_n_q;
  assign ee_oe_n_o   = oe_n_q;
  assign ee_we_n_o   = we_n_q;
  assign ee_io_oe_o  = io_oe_q;
  assign ee_io_out_o = wdata_q;

endmodule

// File: tb/tb_eeprom_word_ctrl.sv
// Bench for eeprom_word_ctrl: behavioural chip model on the bus plus a word-level
// reference memory; directed scenarios followed by randomized traffic.
module tb_eeprom_word_ctrl;

  localparam int unsigned AW    = 13;
  localparam int unsigned TAS   = 1;
  localparam int unsigned TACC  = 4;
  localparam int unsigned TWP   = 3;
  localparam int unsigned TWC   = 16;
  localparam int          RdLat = TAS + TACC + 1;
  localparam int          WrLat = TAS + TWP + 1 + TWC + 1;

  logic          clk, rst_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] ee_a;
  logic          ee_ce_n, ee_oe_n, ee_we_n, ee_io_oe;
  logic [31:0]   ee_io_out, ee_io_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Bus-side chip model state (written only by the monitor process).
  logic [31:0] chip_mem [int];
  int          oe_run;
  bit          we_lo_prev;
  bit          ce_lo_prev;
  logic [AW-1:0] a_prev;
  bit          bus_force;
  logic [31:0] bus_force_val;
  int          oe_lo, we_lo, io_hi;

  // Request-level reference memory.
  logic [31:0] ref_mem [int];

  eeprom_word_ctrl #(
    .ADDR_W(AW), .T_AS(TAS), .T_ACC(TACC), .T_WP(TWP), .T_WC(TWC)
  ) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_we_i   (req_we),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .ee_a_o     (ee_a),
    .ee_ce_n_o  (ee_ce_n),
    .ee_oe_n_o  (ee_oe_n),
    .ee_we_n_o  (ee_we_n),
    .ee_io_oe_o (ee_io_oe),
    .ee_io_out_o(ee_io_out),
    .ee_io_in_i (ee_io_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Unwritten locations read back as byte k = addr + k.
  function automatic logic [31:0] pat(input logic [AW-1:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a);
  endfunction

  // Chip model + invariant monitor, evaluated mid-cycle; drives ee_io_in for the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      oe_run     = 0;
      we_lo_prev = 1'b0;
      ce_lo_prev = 1'b0;
      ee_io_in   = 32'hBAD0_BAD0;
    end else begin
      chk("inv_oe_and_we", {31'b0, !ee_oe_n && !ee_we_n}, 32'd0);
      chk("inv_io_oe_and_oe", {31'b0, ee_io_oe && !ee_oe_n}, 32'd0);
      chk("inv_strobe_without_ce", {31'b0, (!ee_oe_n || !ee_we_n) && ee_ce_n}, 32'd0);
      if (!ee_ce_n && ce_lo_prev) chk("inv_addr_stable", {19'b0, ee_a}, {19'b0, a_prev});
      if (we_lo_prev && ee_we_n && !ee_ce_n && ee_io_oe) chip_mem[int'(ee_a)] = ee_io_out;
      if (!ee_oe_n) oe_lo++;
      if (!ee_we_n) we_lo++;
      if (ee_io_oe) io_hi++;
      oe_run     = ee_oe_n ? 0 : oe_run + 1;
      we_lo_prev = !ee_we_n;
      ce_lo_prev = !ee_ce_n;
      a_prev     = ee_a;
      // Data becomes valid only once access time has elapsed.
      if (!ee_oe_n && !ee_ce_n && oe_run >= int'(TACC)) begin
        if (bus_force) ee_io_in = bus_force_val;
        else ee_io_in = chip_mem.exists(int'(ee_a)) ? chip_mem[int'(ee_a)] : pat(ee_a);
      end else begin
        ee_io_in = 32'hBAD0_BAD0;
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic do_op(input bit we, input logic [AW-1:0] addr, input logic [31:0] wd,
                       input int hold, input bit force_bus);
    logic [31:0] exp;
    int n;
    exp = we ? wd : (force_bus ? bus_force_val : ref_rd(addr));
    wait_ready();
    bus_force = force_bus;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    rsp_ready = (hold == 0);
    @(posedge clk);
    oe_lo = 0;
    we_lo = 0;
    io_hi = 0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, we ? WrLat : RdLat);
    chk("rsp_rdata", rsp_rdata, exp);
    chk("ee_a", {19'b0, ee_a}, {19'b0, addr});
    chk("oe_low_cycles", oe_lo, we ? 0 : TACC);
    chk("we_low_cycles", we_lo, we ? TWP : 0);
    chk("io_oe_cycles", io_hi, we ? TAS + TWP + 1 : 0);
    if (we) begin
      chk("ee_io_out", ee_io_out, wd);
      ref_mem[int'(addr)] = wd;
    end
    if (hold > 0) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = ~addr;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("hold_rsp_rdata", rsp_rdata, exp);
        chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("release_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("release_req_ready", {31'b0, req_ready}, 32'd1);
    end
    bus_force = 1'b0;
  endtask

  initial begin
    int n;
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_we        = 1'b0;
    req_addr      = '0;
    req_wdata     = '0;
    rsp_ready     = 1'b1;
    bus_force     = 1'b0;
    bus_force_val = 32'h0;
    ee_io_in      = 32'hBAD0_BAD0;
    oe_lo = 0; we_lo = 0; io_hi = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ce_n", {31'b0, ee_ce_n}, 32'd1);
    chk("rst_oe_n", {31'b0, ee_oe_n}, 32'd1);
    chk("rst_we_n", {31'b0, ee_we_n}, 32'd1);
    chk("rst_io_oe", {31'b0, ee_io_oe}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_ee_a", {19'b0, ee_a}, 32'd0);
    chk("rst_io_out", ee_io_out, 32'd0);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_edge", {31'b0, req_ready}, 32'd1);

    // Forced bus data, top address
    bus_force_val = 32'hDEAD_BEEF;
    do_op(1'b0, 13'h1FFF, 32'h0, 0, 1'b1);
    // Write, then read it back through the chip model while holding off the response
    do_op(1'b1, 13'h0042, 32'h6A09_E667, 0, 1'b0);
    do_op(1'b0, 13'h0042, 32'h0, 10, 1'b0);
    // Back-to-back reads of untouched locations
    do_op(1'b0, 13'h0000, 32'h0, 0, 1'b0);
    do_op(1'b0, 13'h0001, 32'h0, 0, 1'b0);
    chk("b2b_word1", rsp_rdata, 32'h0403_0201);

    // Reset during the write pulse
    wait_ready();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 13'h0777;
    req_wdata = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (ee_we_n && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_saw_we_low", {31'b0, ee_we_n}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_we_n", {31'b0, ee_we_n}, 32'd1);
    chk("abort_ce_n", {31'b0, ee_ce_n}, 32'd1);
    chk("abort_io_oe", {31'b0, ee_io_oe}, 32'd0);
    chk("abort_req_ready", {31'b0, req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 13'h0042, 32'h0, 0, 1'b0);

    // Randomized traffic over a small address window to hit read-after-write
    for (int i = 0; i < 16; i++) begin
      do_op(1'($urandom_range(0, 1)), AW'(13'h100 + $urandom_range(0, 7)), $urandom,
            int'($urandom_range(0, 2)), 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
